// File: rtl/rs_sync_fifo_afe.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty thresholds,
// selectable FWFT or registered read, and sticky overflow/underflow error flags.
module rs_sync_fifo_afe #(
  parameter int DATASIZE   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 1,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int ADDRSIZE  = $clog2(FIFO_DEPTH),
  localparam int CNTSIZE   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [DATASIZE-1:0] wr_data,
  output logic                full,
  output logic                almost_full,
  input  logic                rd,
  output logic [DATASIZE-1:0] rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                almost_empty,
  output logic [CNTSIZE-1:0]  count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam logic [ADDRSIZE-1:0] LAST_PTR = ADDRSIZE'(FIFO_DEPTH - 1);
  localparam logic [CNTSIZE-1:0]  CNT_FULL = CNTSIZE'(FIFO_DEPTH);
  localparam logic [CNTSIZE-1:0]  CNT_AF   = CNTSIZE'(AF_THRESH);
  localparam logic [CNTSIZE-1:0]  CNT_AE   = CNTSIZE'(AE_THRESH);

  logic [DATASIZE-1:0] mem_q [FIFO_DEPTH];
  logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRSIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTSIZE-1:0]  count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_acc, rd_acc;

  // Flags decode from the count register only, never from wr/rd.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDRSIZE'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDRSIZE'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNTSIZE'(1);
      2'b01:   count_d = count_q - CNTSIZE'(1);
      default: count_d = count_q;
    endcase
    // A new violation in the same cycle as clr_err keeps the flag set.
    overflow_d  = (wr & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem_q[rd_ptr_q];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [DATASIZE-1:0] rd_data_q, rd_data_d;
      logic                rd_valid_q, rd_valid_d;

      always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule
